// File: rtl/sme_pe_result_collector_if.sv
// Bundle between the string-match PE array / result comparator and the PE result collector.
// Handshake: o_valid is a level held (bus and done_mask frozen) until res_ack is seen; the cycle after the ack o_valid drops.
interface sme_pe_result_collector_if #(
  parameter int NUM_PE  = 4,
  parameter int ADDR_W  = 5,
  parameter int LOCAL_W = 3
);
  logic                          start;
  logic [NUM_PE-1:0]             pe_done;
  logic [NUM_PE-1:0]             pe_match;
  logic [NUM_PE*LOCAL_W-1:0]     pe_addr;
  logic                          res_ack;
  logic [NUM_PE*(ADDR_W+1)-1:0]  o_pe_result;
  logic                          o_valid;
  logic                          busy;
  logic [NUM_PE-1:0]             done_mask;
  logic                          o_timeout;
  logic [1:0]                    state_dbg;

  modport master (
    output start, pe_done, pe_match, pe_addr, res_ack,
    input  o_pe_result, o_valid, busy, done_mask, o_timeout, state_dbg
  );

  modport slave (
    input  start, pe_done, pe_match, pe_addr, res_ack,
    output o_pe_result, o_valid, busy, done_mask, o_timeout, state_dbg
  );
endinterface

// File: rtl/sme_pe_result_collector.sv
// Collects per-PE hit results for one search round, converts them to global addresses and presents them packed.
// Optional forced completion after TIMEOUT_CYC collect cycles when SME_COLLECT_TIMEOUT_EN is defined.
module sme_pe_result_collector #(
  parameter int NUM_PE      = 4,
  parameter int ADDR_W      = 5,
  parameter int LOCAL_W     = 3,
  parameter int SEG_LEN     = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                  clk,
  input logic                  reset,
  sme_pe_result_collector_if.slave bus
);
  localparam int SLOT_W = ADDR_W + 1;
  localparam logic [SLOT_W-1:0] MISS = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [NUM_PE-1:0]          mask_q;
  logic [NUM_PE-1:0]          cap;
  logic [NUM_PE-1:0]          mask_next;
  logic [NUM_PE*SLOT_W-1:0]   slots_q;
  logic [NUM_PE*SLOT_W-1:0]   slot_cap;
  logic                       start_round;

  // Slot value a PE would write if captured this cycle: global address on hit, all ones on miss.
  for (genvar i = 0; i < NUM_PE; i++) begin : g_slot
    logic [ADDR_W-1:0] global_addr;
    assign global_addr = ADDR_W'(i * SEG_LEN) + ADDR_W'(bus.pe_addr[i*LOCAL_W +: LOCAL_W]);
    assign slot_cap[i*SLOT_W +: SLOT_W] = bus.pe_match[i] ? {1'b0, global_addr} : MISS;
  end

  assign mask_next = mask_q | cap;

`ifdef SME_COLLECT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             timeout_hit;
  logic             timeout_q;
`endif

  always_comb begin
    state_d     = state_q;
    cap         = '0;
    start_round = 1'b0;
`ifdef SME_COLLECT_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_COLLECT;
          start_round = 1'b1;
        end
      end
      S_COLLECT: begin
        cap = bus.pe_done & ~mask_q;
        // A last-slot capture wins over a simultaneous timeout.
        if (&mask_next) begin
          state_d = S_PRESENT;
        end
`ifdef SME_COLLECT_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d     = S_PRESENT;
          timeout_hit = 1'b1;
        end
`endif
      end
      S_PRESENT: begin
        if (bus.res_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset || start_round) begin
      slots_q <= {NUM_PE{MISS}};
      mask_q  <= '0;
    end else begin
      mask_q <= mask_next;
      for (int i = 0; i < NUM_PE; i++) begin
        if (cap[i]) slots_q[i*SLOT_W +: SLOT_W] <= slot_cap[i*SLOT_W +: SLOT_W];
      end
    end
  end

`ifdef SME_COLLECT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset || start_round)     tmo_cnt_q <= '0;
    else if (state_q == S_COLLECT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || start_round) timeout_q <= 1'b0;
    else if (timeout_hit)     timeout_q <= 1'b1;
  end

  assign bus.o_timeout = timeout_q;
`else
  assign bus.o_timeout = 1'b0;
`endif

  assign bus.o_pe_result = slots_q;
  assign bus.done_mask   = mask_q;
  assign bus.o_valid     = (state_q == S_PRESENT);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_sme_pe_result_collector.sv
// Scoreboard bench for sme_pe_result_collector: random rounds against a per-PE first-event model.
// Builds with or without SME_COLLECT_TIMEOUT_EN; the forced-completion round runs only when it is defined.
module tb_sme_pe_result_collector;
  localparam int NUM_PE  = 4;
  localparam int ADDR_W  = 5;
  localparam int LOCAL_W = 3;
  localparam int SEG_LEN = 8;
  localparam int TMO     = 64;
  localparam int SLOT_W  = ADDR_W + 1;
  localparam int RES_W   = NUM_PE * SLOT_W;
  localparam int W       = 1 + NUM_PE + RES_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic         prev_valid = 1'b0;

  // Round description consumed by run_round
  int   r_first[NUM_PE];
  bit   r_match[NUM_PE];
  int   r_addr[NUM_PE];
  bit   r_rep[NUM_PE];
  int   r_rep_at[NUM_PE];
  bit   r_rep_match[NUM_PE];
  int   r_rep_addr[NUM_PE];
  int   r_mid_start;

  sme_pe_result_collector_if #(.NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .LOCAL_W(LOCAL_W)) bus ();

  sme_pe_result_collector #(
    .NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .LOCAL_W(LOCAL_W), .SEG_LEN(SEG_LEN), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising o_valid must match the oldest expected round, at the expected cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.o_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          logic [W-1:0] e;
          int ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("present_result", 64'(bus.o_pe_result), 64'(e[RES_W-1:0]));
          check("present_mask", 64'(bus.done_mask), 64'(e[RES_W +: NUM_PE]));
          check("present_timeout", 64'(bus.o_timeout), 64'(e[W-1]));
          check("present_latency", 64'(cyc), 64'(ec));
        end
      end
      prev_valid = bus.o_valid;
    end
  end

  function automatic logic [RES_W-1:0] model_slots();
    logic [RES_W-1:0] r;
    for (int i = 0; i < NUM_PE; i++) begin
      int v;
      v = r_match[i] ? (i * SEG_LEN + r_addr[i]) : (2 ** SLOT_W - 1);
      r[i*SLOT_W +: SLOT_W] = SLOT_W'(v);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.pe_done = '0; bus.pe_match = '0; bus.pe_addr = '0; bus.res_ack = 1'b0;
  endtask

  task automatic no_repeats();
    for (int i = 0; i < NUM_PE; i++) r_rep[i] = 1'b0;
    r_mid_start = -1;
  endtask

  // Drives one full round, pushes its expectation, then acknowledges and checks the release.
  task automatic run_round(input int wait_extra, input bit ack_start);
    int s, maxf, span;
    logic [RES_W-1:0] exp_res;
    exp_res = model_slots();
    maxf = 0; span = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (r_first[i] > maxf) maxf = r_first[i];
      if (r_first[i] > span) span = r_first[i];
      if (r_rep[i] && r_rep_at[i] > span) span = r_rep_at[i];
    end
    bus.start = 1'b1;
    s = cyc;
    exp_q.push_back({1'b0, {NUM_PE{1'b1}}, exp_res});
    exp_cyc_q.push_back(s + 2 + maxf);
    tick();
    bus.start = 1'b0;
    for (int d = 0; d <= span; d++) begin
      bus.pe_done = '0; bus.pe_match = '0; bus.pe_addr = '0;
      for (int i = 0; i < NUM_PE; i++) begin
        if (r_first[i] == d) begin
          bus.pe_done[i] = 1'b1; bus.pe_match[i] = r_match[i];
          bus.pe_addr[i*LOCAL_W +: LOCAL_W] = LOCAL_W'(r_addr[i]);
        end else if (r_rep[i] && r_rep_at[i] == d) begin
          bus.pe_done[i] = 1'b1; bus.pe_match[i] = r_rep_match[i];
          bus.pe_addr[i*LOCAL_W +: LOCAL_W] = LOCAL_W'(r_rep_addr[i]);
        end
      end
      bus.start = (d == r_mid_start);
      tick();
    end
    clear_inputs();
    for (int k = 0; k < wait_extra; k++) tick();
    check("held_valid", 64'(bus.o_valid), 64'd1);
    check("held_result", 64'(bus.o_pe_result), 64'(exp_res));
    bus.res_ack = 1'b1;
    bus.start   = ack_start;
    tick();
    clear_inputs();
    check("ack_valid_low", 64'(bus.o_valid), 64'd0);
    check("ack_busy_low", 64'(bus.busy), 64'd0);
    check("ack_slots_kept", 64'(bus.o_pe_result), 64'(exp_res));
    tick();
    check("idle_after_ack", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    check("reset_valid", 64'(bus.o_valid), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_slots", 64'(bus.o_pe_result), 64'(24'hFFFFFF));
    check("reset_mask", 64'(bus.done_mask), 64'd0);
    check("reset_timeout", 64'(bus.o_timeout), 64'd0);

    // PE0..3 hit one per cycle with local addresses 3,1,7,0
    no_repeats();
    for (int i = 0; i < NUM_PE; i++) begin
      r_first[i] = i; r_match[i] = 1'b1;
    end
    r_addr[0] = 3; r_addr[1] = 1; r_addr[2] = 7; r_addr[3] = 0;
    run_round(2, 1'b0);

    // All done together; only PE2 hits at local 5
    no_repeats();
    for (int i = 0; i < NUM_PE; i++) begin
      r_first[i] = 0; r_match[i] = (i == 2); r_addr[i] = (i == 2) ? 5 : 6;
    end
    run_round(0, 1'b1);

    // Repeat on PE1 with different data plus a start pulse mid-round
    no_repeats();
    for (int i = 0; i < NUM_PE; i++) begin
      r_first[i] = (i == 1) ? 0 : 3; r_match[i] = 1'b1; r_addr[i] = i + 2;
    end
    r_rep[1] = 1'b1; r_rep_at[1] = 1; r_rep_match[1] = 1'b1; r_rep_addr[1] = 6;
    r_mid_start = 2;
    run_round(1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      no_repeats();
      for (int i = 0; i < NUM_PE; i++) begin
        r_first[i]     = $urandom_range(0, 6);
        r_match[i]     = 1'($urandom_range(0, 1));
        r_addr[i]      = $urandom_range(0, 7);
        r_rep[i]       = 1'($urandom_range(0, 1));
        r_rep_at[i]    = r_first[i] + $urandom_range(1, 4);
        r_rep_match[i] = 1'($urandom_range(0, 1));
        r_rep_addr[i]  = $urandom_range(0, 7);
      end
      r_mid_start = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : -1;
      run_round($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset while presenting
    bus.start = 1'b1;
    for (int i = 0; i < NUM_PE; i++) begin
      r_first[i] = 0; r_match[i] = 1'b1; r_addr[i] = 1;
    end
    exp_q.push_back({1'b0, {NUM_PE{1'b1}}, model_slots()});
    exp_cyc_q.push_back(cyc + 2);
    tick();
    bus.start = 1'b0;
    bus.pe_done = '1; bus.pe_match = '1; bus.pe_addr = {NUM_PE{3'd1}};
    tick();
    clear_inputs();
    repeat (2) tick();
    check("pre_reset_valid", 64'(bus.o_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_present_valid", 64'(bus.o_valid), 64'd0);
    check("rst_present_busy", 64'(bus.busy), 64'd0);
    check("rst_present_slots", 64'(bus.o_pe_result), 64'(24'hFFFFFF));
    check("rst_present_mask", 64'(bus.done_mask), 64'd0);
    bus.res_ack = 1'b1;
    tick();
    bus.res_ack = 1'b0;
    tick();
    check("ack_after_reset_busy", 64'(bus.busy), 64'd0);
    check("ack_after_reset_valid", 64'(bus.o_valid), 64'd0);

`ifdef SME_COLLECT_TIMEOUT_EN
    // Only PE0 reports (hit local 2); the round is forced after TMO collect cycles
    begin
      int s;
      bus.start = 1'b1;
      s = cyc;
      exp_q.push_back({1'b1, 4'b0001, 18'h3FFFF, 6'd2});
      exp_cyc_q.push_back(s + 1 + TMO);
      tick();
      bus.start = 1'b0;
      bus.pe_done = 4'b0001; bus.pe_match = 4'b0001; bus.pe_addr = 12'd2;
      tick();
      clear_inputs();
      repeat (TMO + 4) tick();
      check("tmo_valid", 64'(bus.o_valid), 64'd1);
      check("tmo_flag", 64'(bus.o_timeout), 64'd1);
      bus.res_ack = 1'b1;
      tick();
      clear_inputs();
      check("tmo_flag_kept_idle", 64'(bus.o_timeout), 64'd1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("tmo_flag_cleared", 64'(bus.o_timeout), 64'd0);
      bus.pe_done = '1;
      exp_q.push_back({1'b0, 4'hF, 24'hFFFFFF});
      exp_cyc_q.push_back(cyc + 1);
      tick();
      clear_inputs();
      bus.res_ack = 1'b1;
      tick();
      clear_inputs();
    end
`endif

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
